// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with same-cycle write-back bypass,
// a pending-write scoreboard for RAW/WAW hazards, and a one-entry output register.
module operand_fetch #(
  parameter int LENGTH         = 16,
  parameter int REG_FILE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [2:0]        in_rs0,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rd,
  input  logic              in_wr,
  output logic              in_ready,
  output logic [2:0]        dataAddr0,
  output logic [2:0]        dataAddr1,
  input  logic [LENGTH-1:0] readData0,
  input  logic [LENGTH-1:0] readData1,
  input  logic              wb_valid,
  input  logic [2:0]        wb_rd,
  input  logic [LENGTH-1:0] wb_data,
  output logic              op_valid,
  output logic [LENGTH-1:0] op_a,
  output logic [LENGTH-1:0] op_b,
  output logic [2:0]        op_rd,
  output logic              op_wr,
  input  logic              op_ready,
  input  logic              flush,
  output logic [3:0]        pending_cnt
);

  logic [REG_FILE_DEPTH-1:0] sb_q, sb_d;
  logic [REG_FILE_DEPTH-1:0] wb_clr, set_vec, flush_clr, sb_eff;
  logic                      op_valid_q, op_valid_d;
  logic [LENGTH-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]                op_rd_q, op_rd_d;
  logic                      op_wr_q, op_wr_d;
  logic                      hazard, accept;
  logic [3:0]                cnt;

  assign dataAddr0 = in_rs0;
  assign dataAddr1 = in_rs1;

  // A write-back landing this cycle already resolves the hazard on its register.
  assign sb_eff   = sb_q & ~wb_clr;
  assign hazard   = sb_eff[in_rs0] | sb_eff[in_rs1] | (in_wr & sb_eff[in_rd]);
  assign in_ready = (~op_valid_q | op_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    wb_clr    = '0;
    set_vec   = '0;
    flush_clr = '0;
    cnt       = '0;
    for (int i = 0; i < REG_FILE_DEPTH; i++) begin
      wb_clr[i]    = wb_valid && (wb_rd == 3'(i));
      set_vec[i]   = accept && in_wr && (in_rd == 3'(i));
      flush_clr[i] = flush && op_valid_q && op_wr_q && (op_rd_q == 3'(i));
      cnt          = cnt + {3'b000, sb_q[i]};
    end
    // Clears applied first so a same-cycle set wins.
    sb_d = (sb_q & ~wb_clr & ~flush_clr) | set_vec;
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    if (flush) begin
      op_valid_d = 1'b0;
    end else if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = (wb_valid && (wb_rd == in_rs0)) ? wb_data : readData0;
      op_b_d     = (wb_valid && (wb_rd == in_rs1)) ? wb_data : readData1;
      op_rd_d    = in_rd;
      op_wr_d    = in_wr;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sb_q       <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_wr_q    <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_wr_q    <= op_wr_d;
    end
  end

  assign op_valid    = op_valid_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_rd       = op_rd_q;
  assign op_wr       = op_wr_q;
  assign pending_cnt = cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: one task per scenario.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [2:0]  in_rs0, in_rs1, in_rd;
  logic        in_wr;
  logic        in_ready;
  logic [2:0]  dataAddr0, dataAddr1;
  logic [15:0] readData0, readData1;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        op_valid;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_rd;
  logic        op_wr;
  logic        op_ready;
  logic        flush;
  logic [3:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  operand_fetch #(.LENGTH(16), .REG_FILE_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd),
    .in_wr(in_wr), .in_ready(in_ready),
    .dataAddr0(dataAddr0), .dataAddr1(dataAddr1),
    .readData0(readData0), .readData1(readData1),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
    .op_ready(op_ready), .flush(flush), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs0 = 0; in_rs1 = 0; in_rd = 0; in_wr = 0;
    readData0 = 0; readData1 = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    op_ready = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    tick(); tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b exp 0", op_valid); end
    checks++; if (op_a !== 16'h0 || op_b !== 16'h0) begin errors++; $display("FAIL reset_op_ab: got %h/%h exp 0/0", op_a, op_b); end
    checks++; if (op_rd !== 3'd0 || op_wr !== 1'b0) begin errors++; $display("FAIL reset_op_rdwr: got %0d/%b exp 0/0", op_rd, op_wr); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d exp 0", pending_cnt); end
    reset_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_issue();
    in_valid = 1; in_rs0 = 1; in_rs1 = 2; in_rd = 3; in_wr = 1;
    readData0 = 16'h0011; readData1 = 16'h0022; op_ready = 0;
    #1;
    checks++; if (dataAddr0 !== 3'd1 || dataAddr1 !== 3'd2) begin errors++; $display("FAIL issue_addr: got %0d/%0d exp 1/2", dataAddr0, dataAddr1); end
    tick();
    in_valid = 0;
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL issue_valid: got %b exp 1", op_valid); end
    checks++; if (op_a !== 16'h0011 || op_b !== 16'h0022) begin errors++; $display("FAIL issue_ops: got %h/%h exp 0011/0022", op_a, op_b); end
    checks++; if (op_rd !== 3'd3 || op_wr !== 1'b1) begin errors++; $display("FAIL issue_rdwr: got %0d/%b exp 3/1", op_rd, op_wr); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL issue_pending: got %0d exp 1", pending_cnt); end
    op_ready = 1;
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL issue_consume: got %b exp 0", op_valid); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL issue_pending_hold: got %0d exp 1", pending_cnt); end
  endtask

  task automatic test_hazard_bypass();
    in_valid = 1; in_rs0 = 3; in_rs1 = 0; in_rd = 0; in_wr = 0;
    readData0 = 16'h1111; readData1 = 16'h0077; op_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_block0: got %b exp 0", in_ready); end
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL hazard_no_accept: got %b exp 0", op_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_block1: got %b exp 0", in_ready); end
    wb_valid = 1; wb_rd = 3; wb_data = 16'hBEEF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b exp 1", in_ready); end
    tick();
    wb_valid = 0; in_valid = 0;
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b exp 1", op_valid); end
    checks++; if (op_a !== 16'hBEEF || op_b !== 16'h0077) begin errors++; $display("FAIL bypass_ops: got %h/%h exp BEEF/0077", op_a, op_b); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL bypass_pending: got %0d exp 0", pending_cnt); end
  endtask

  task automatic test_back_to_back();
    op_ready = 0;
    in_valid = 1; in_rs0 = 4; in_rs1 = 5; in_rd = 1; in_wr = 0;
    readData0 = 16'h1234; readData1 = 16'h5678;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b exp 0", c, in_ready); end
      tick();
      checks++;
      if (op_valid !== 1'b1 || op_a !== 16'hBEEF || op_b !== 16'h0077 || op_rd !== 3'd0) begin
        errors++; $display("FAIL stall_hold c%0d: got %b %h %h %0d exp 1 BEEF 0077 0", c, op_valid, op_a, op_b, op_rd);
      end
    end
    op_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (op_valid !== 1'b1 || op_a !== 16'h1234 || op_b !== 16'h5678 || op_rd !== 3'd1) begin
      errors++; $display("FAIL b2b_accept: got %b %h %h %0d exp 1 1234 5678 1", op_valid, op_a, op_b, op_rd);
    end
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", op_valid); end
  endtask

  task automatic test_set_wins();
    op_ready = 1;
    in_valid = 1; in_rs0 = 0; in_rs1 = 0; in_rd = 5; in_wr = 1;
    tick();
    in_valid = 0;
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL setwin_first: got %0d exp 1", pending_cnt); end
    tick();
    in_valid = 1; wb_valid = 1; wb_rd = 5; wb_data = 16'h0055;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL setwin_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 0; wb_valid = 0;
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL setwin_pending: got %0d exp 1", pending_cnt); end
    in_rs0 = 5;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL setwin_bit5: got %b exp 0", in_ready); end
    in_rs0 = 0; wb_valid = 1; wb_rd = 5;
    tick();
    wb_valid = 0;
    tick();
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL setwin_clear: got %0d exp 0", pending_cnt); end
  endtask

  task automatic test_flush();
    op_ready = 0;
    in_valid = 1; in_rs0 = 0; in_rs1 = 0; in_rd = 6; in_wr = 1;
    tick();
    checks++; if (op_valid !== 1'b1 || op_rd !== 3'd6 || pending_cnt !== 4'd1) begin
      errors++; $display("FAIL flush_setup: got %b %0d %0d exp 1 6 1", op_valid, op_rd, pending_cnt);
    end
    in_rd = 0; in_wr = 0; flush = 1; op_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", op_valid); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL flush_pending: got %0d exp 0", pending_cnt); end
    in_rs0 = 6;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_bit6: got %b exp 1", in_ready); end
  endtask

  task automatic test_fill_reset();
    op_ready = 1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1; in_rs0 = 3'(r); in_rs1 = 3'(r); in_rd = 3'(r); in_wr = 1;
      tick();
    end
    in_valid = 0; in_wr = 0;
    checks++; if (pending_cnt !== 4'd8) begin errors++; $display("FAIL fill_pending: got %0d exp 8", pending_cnt); end
    checks++; if (op_valid !== 1'b1 || op_rd !== 3'd7) begin errors++; $display("FAIL fill_last: got %b %0d exp 1 7", op_valid, op_rd); end
    reset_n = 0;
    tick();
    reset_n = 1;
    checks++; if (pending_cnt !== 4'd0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL midreset: got %0d %b exp 0 0", pending_cnt, op_valid);
    end
    wb_valid = 1; wb_rd = 2; wb_data = 16'hDEAD;
    tick();
    wb_valid = 0;
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL stale_wb: got %0d exp 0", pending_cnt); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_hazard_bypass();
    test_back_to_back();
    test_set_wins();
    test_flush();
    test_fill_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
